// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder scheduler and its arbiter.
package fp_add_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Raw IEEE-754 single-precision word
    typedef logic [31:0] fp32_t;

    // Quiet NaN returned when the watchdog gives up on the core
    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first asserted request
// found searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    logic [ID_W-1:0] cand_s;

    // Rotating priority search starting just after the previous owner
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand_s    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any_grant && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                any_grant     = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one multi-cycle FP adder core among NUM_REQ requesters: round-robin
// grant, operand capture, start/done sequencing, watchdog and tagged return.
// Optional statistics counters are built when FPADD_SCHED_STATS_EN is defined.
module fp_add_scheduler
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic [31:0]           core_a,
    output logic [31:0]           core_b,
    input  logic                  core_done,
    input  logic [31:0]           core_result,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
`ifdef FPADD_SCHED_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [15:0]           stat_timeouts
`endif
);

    localparam int              CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [ID_W-1:0]     last_grant_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [ID_W-1:0]     arb_idx_s;
    logic                arb_any_s;
    logic                accept_s;
    logic                done_s;
    logic                timeout_s;
    logic                rsp_hs_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any_grant  (arb_any_s)
    );

    // Next-state decode and the combinational accept toward the winner
    always_comb begin
        state_next_s = state_r;
        req_ready    = '0;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        rsp_hs_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!reset && arb_any_s) begin
                    req_ready    = arb_grant_s;
                    accept_s     = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                // A done arriving in the last watchdog cycle still wins
                if (core_done) begin
                    done_s       = 1'b1;
                    state_next_s = RESP;
                end else if (wait_cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready[grant_id]) begin
                    rsp_hs_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_INIT;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= '0;
        end else begin
            state_r    <= state_next_s;
            core_start <= (state_next_s == ISSUE);
            busy       <= (state_next_s != IDLE);
            rsp_valid  <= (state_next_s == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
            if (rsp_hs_s) begin
                last_grant_r <= grant_id;
            end
        end
    end

    // Operand and owner capture on the request handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_a   <= '0;
            core_b   <= '0;
            grant_id <= '0;
        end else if (accept_s) begin
            core_a   <= req_a[32*arb_idx_s +: 32];
            core_b   <= req_b[32*arb_idx_s +: 32];
            grant_id <= arb_idx_s;
        end
    end

    // Watchdog counter: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end

    // Result word: core sum on done, quiet NaN with error on watchdog expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (done_s) begin
            rsp_data <= core_result;
            rsp_err  <= 1'b0;
        end else if (timeout_s) begin
            rsp_data <= FP32_QNAN;
            rsp_err  <= 1'b1;
        end
    end

`ifdef FPADD_SCHED_STATS_EN
    // Saturating counters of good completions and watchdog events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops      <= '0;
            stat_timeouts <= '0;
        end else begin
            if (rsp_hs_s && !rsp_err && (stat_ops != 32'hFFFF_FFFF)) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (timeout_s && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one multi-cycle single-precision FP adder core (unpack/align/add/normalize/round) among NUM_REQ requesters.
- Round-robin arbitration, operand capture, core start/done sequencing, watchdog timeout, and per-requester tagged result return.
- Sits between requester-side handshakes and the adder datapath; one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before the watchdog forces an error result (≥2).
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  one-hot accept; only the winner, only in IDLE.
- req_a  input  NUM_REQ*32  operand A per requester, slice i = [32i+31:32i].
- req_b  input  NUM_REQ*32  operand B per requester, same slicing.
- rsp_valid  output  NUM_REQ  one-hot result valid to the owning requester.
- rsp_ready  input  NUM_REQ  per-requester result accept.
- rsp_data  output  32  result word, shared by all requesters.
- rsp_err  output  1  result produced by the watchdog, not the core.
- core_start  output  1  single-cycle start pulse to the adder core.
- core_a  output  32  registered operand A to the core.
- core_b  output  32  registered operand B to the core.
- core_done  input  1  core result valid, single-cycle pulse.
- core_result  input  32  core sum.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  ID_W  index of the current or last owner.

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority; watchdog counter 0.
- IDLE:
  - Winner = first asserted req_valid searching last_grant+1, +2, … modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On handshake: latch req_a/req_b slices into core_a/core_b, latch winner into grant_id, go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: core_start=1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - core_done=1: capture core_result into rsp_data, rsp_err=0, go to RESP.
  - Counter reaching TIMEOUT-1 with no done: rsp_data=32'h7FC00000 (quiet NaN), rsp_err=1, go to RESP.
  - core_done in the timeout cycle: done wins, rsp_err=0.
- RESP:
  - rsp_valid[grant_id]=1, with rsp_data/rsp_err held stable until rsp_ready[grant_id]=1.
  - Then last_grant=grant_id and go to IDLE; rsp_valid drops the next cycle.
  - rsp_ready of other requesters is ignored.
- core_done outside WAIT (late done after timeout, or done in the ISSUE cycle) is ignored; the core must have ≥1 cycle latency after core_start.
- Minimum latency: handshake edge → core_start at +1 → done at +2 or later → rsp_valid on the cycle after done.
- Throughput: one operation per (core latency + 3) cycles minimum; the owner can never be regranted back-to-back while another requester is waiting.
- Operands are not modified; NaN/Inf/zero handling belongs to the core.
- Reset mid-operation returns everything to reset values immediately; the in-flight operation is dropped and no rsp_valid is issued. The core shares the same reset.

Optional Feature:
- FPADD_SCHED_STATS_EN defined:
  - Adds outputs stat_ops (32-bit, increments on each RESP handshake with rsp_err=0) and stat_timeouts (16-bit, increments on each watchdog event).
  - Both saturate and never wrap; both reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package fp_add_pkg:
  - typedef state_t enum {IDLE, ISSUE, WAIT, RESP}
  - typedef fp32_t (32-bit)
  - constant FP32_QNAN=32'h7FC00000
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot winner from req vector and last_grant; also outputs the encoded index. Reused elsewhere in the FPU.
- All sequencing stays in fp_add_scheduler.

Test Plan:
- Single op: req 0 sends A=3F800000, B=40000000; core model has 3-cycle latency → core_start 1 cycle after handshake, rsp_valid[0] with rsp_data=40400000, rsp_err=0.
- Fairness: reqs 0..3 held valid continuously → grants in order 0,1,2,3,0; no requester is granted twice before all others have been served.
- Backpressure: rsp_ready[1] held low for 10 cycles → rsp_valid[1] and rsp_data stable throughout; no new req_ready asserted until release.
- Timeout: core never asserts done, TIMEOUT=64 → rsp_data=7FC00000, rsp_err=1 exactly 64 WAIT cycles after core_start; a late core_done afterwards is ignored.
- Reset mid-op: assert reset during WAIT → busy=0, core_start=0, rsp_valid=0 immediately; next request is granted to requester 0.
- Stats (FPADD_SCHED_STATS_EN): 5 good ops and 1 timeout → stat_ops=5, stat_timeouts=1.
